isqrt_pipe: RTL and testbench
=============================

Name: isqrt_pipe

Overview:
- Fully pipelined 32-bit unsigned integer square root: y = floor(sqrt(x)).
- Sits directly downstream of the formula FSMs. Their isqrt_x_vld/isqrt_x drive x_vld/x, and y_vld/y return as isqrt_y_vld/isqrt_y.
- Accepts one argument per cycle with no stall and returns results in order after a fixed latency.

Parameters:
- n_pipe_stages, 4, number of register stages. Must be one of 1, 2, 4, 8, 16; any other value is an elaboration error. Each stage performs 16 / n_pipe_stages iterations.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-low (0 = reset asserted)
- x_vld  input  1  argument valid; x is accepted on every rising edge where x_vld = 1
- x  input  32  unsigned radicand
- y_vld  output  1  result valid, asserted for exactly one cycle per accepted argument
- y  output  16  floor(sqrt(x)) for the corresponding argument

Behaviour:
- Reset (rst = 0, asynchronous, takes effect immediately):
  - Clears every stage valid bit, so y_vld = 0.
  - Clears every stage data register, so y = 0.
  - Anything in flight is discarded and never produces y_vld.
  - First acceptance is on the first rising edge with rst = 1.
- Handshake:
  - No ready or backpressure signal; the consumer must always accept.
  - x is sampled on every edge with x_vld = 1. x is don't-care when x_vld = 0.
- Latency:
  - An argument sampled at edge k produces y_vld = 1 with its y after edge k + n_pipe_stages - 1, i.e. visible in the cycle following that edge.
  - Registered output, no combinational path from x to y.
- Throughput:
  - 1 result per cycle. Back-to-back, bubbled and arbitrary valid patterns are reproduced exactly at the output, delayed by the latency.
  - Results are in order.
- Algorithm: bit-pair digit recurrence, 16 iterations total, i = 0..15, split evenly across stages.
  - State per in-flight item:
    - op: 32-bit remainder, initialised to x
    - r: 32-bit partial root, initialised to 0
    - one: 32-bit, initialised to 1 << 30
  - Each iteration:
    - t = r + one
    - if op >= t: op = op - t, r = (r >> 1) + one
    - else: r = r >> 1
    - then one = one >> 2
  - After 16 iterations, y = r[15:0]. The upper bits of r are 0 by construction.
  - one is a function of the iteration index only. It is a constant per iteration, not carried in registers.
- Width rules:
  - All compares and subtracts are 32-bit unsigned; t never exceeds 32 bits.
  - y saturates naturally at 65535 for x >= 0xFFFE0001.
- Valid tracking:
  - Per-stage valid shift chain, each bit following its stage's data.
  - Data registers may load every cycle, or only when the incoming valid = 1. Either choice is acceptable, but y must never change while y_vld = 0 after reset unless a valid result arrives. Implement the load-on-valid option.
- Boundary cases:
  - x = 0 -> y = 0.
  - x = 0xFFFFFFFF -> y = 65535.
  - Perfect squares are exact.
  - x = n² - 1 -> y = n - 1.
- Reset mid-stream: all pending results are lost and y_vld stays 0 until new arguments traverse the full latency.

Test Plan:
- Reset check: rst = 0 for 3 cycles while x_vld = 1 and x = 100 -> y_vld = 0 and y = 0 throughout. After release, no spurious y_vld.
- Single arguments, n_pipe_stages = 4, each sent in isolation:
  - x = 0 -> y = 0
  - x = 1 -> y = 1
  - x = 15 -> y = 3
  - x = 16 -> y = 4
  - x = 0xFFFE0001 -> y = 65535
  - x = 0xFFFFFFFF -> y = 65535
  - x = 0xFFFE0000 -> y = 65534
  - y_vld appears exactly 4 cycles after x_vld.
- Back-to-back stream: x_vld = 1 for 8 consecutive cycles with x = 0, 4, 9, 99, 100, 1000000, 2, 3 -> 8 consecutive y_vld with y = 0, 2, 3, 9, 10, 1000, 1, 1, in order.
- Bubbles: x_vld pattern 1,0,0,1,1,0,1 with x = 49, -, -, 50, 48, -, 225 -> y_vld pattern identical but delayed by the latency, with y = 7, 7, 6, 15.
- Mid-flight reset: issue 3 arguments, pulse rst = 0 for 1 cycle before any result emerges -> no y_vld for those arguments. A new x = 81 after release -> y = 9 after full latency.
- Parameter sweep: n_pipe_stages = 1, 2, 8, 16 with 10000 random x checked against a reference model -> latency equals n_pipe_stages and all y match.

Source files
------------

// File: rtl/isqrt_pipe.sv
// Pipelined 32-bit unsigned integer square root, y = floor(sqrt(x)), bit-pair digit recurrence.
// Latency: n_pipe_stages cycles from the x_vld sample edge to registered y_vld/y; one result per cycle.
// Backpressure: none. The consumer must take every y_vld pulse; x is accepted on every edge with x_vld = 1.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - asynchronous reset, active-low; clears all valid and data registers
//   x_vld  - argument valid, x sampled on every rising edge where it is 1
//   x      - 32-bit unsigned radicand
//   y_vld  - one-cycle result valid per accepted argument, in order
//   y      - 16-bit floor(sqrt(x)); holds its value between results
module isqrt_pipe #(
    parameter int n_pipe_stages = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);

    localparam int N     = n_pipe_stages;
    localparam int ITERS = 16 / n_pipe_stages;

    if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_param
        $error("isqrt_pipe: n_pipe_stages must be 1, 2, 4, 8 or 16");
    end

    // Per-stage state: remainder, partial root and valid bit.
    logic [31:0]  op_q [N];
    logic [31:0]  r_q  [N];
    logic [N-1:0] vld_q;

    logic [31:0]  op_d [N];
    logic [31:0]  r_d  [N];
    logic [N-1:0] vld_d;

    // Each stage takes the previous stage's registers (stage 0 takes x with a
    // zero root) and runs its slice of the 16 iterations. The "one" bit for
    // global iteration i is 1 << (30 - 2i), so it is a constant per iteration
    // and never needs to travel down the pipe.
    always_comb begin
        logic [31:0] op_v;
        logic [31:0] r_v;
        logic [31:0] one;
        logic [31:0] t;
        int          prev;
        op_v = '0;
        r_v  = '0;
        one  = '0;
        t    = '0;
        prev = 0;
        for (int s = 0; s < N; s++) begin
            prev = (s > 0) ? s - 1 : 0;
            if (s == 0) begin
                op_v     = x;
                r_v      = '0;
                vld_d[s] = x_vld;
            end else begin
                op_v     = op_q[prev];
                r_v      = r_q[prev];
                vld_d[s] = vld_q[prev];
            end
            for (int j = 0; j < ITERS; j++) begin
                one = 32'h4000_0000 >> (2 * (s * ITERS + j));
                t   = r_v + one;
                if (op_v >= t) begin
                    op_v = op_v - t;
                    r_v  = (r_v >> 1) + one;
                end else begin
                    r_v  = r_v >> 1;
                end
            end
            op_d[s] = op_v;
            r_d[s]  = r_v;
        end
    end

    // Data registers load only with a valid item so y holds between results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int s = 0; s < N; s++) begin
                op_q[s] <= '0;
                r_q[s]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < N; s++) begin
                if (vld_d[s]) begin
                    op_q[s] <= op_d[s];
                    r_q[s]  <= r_d[s];
                end
            end
        end
    end

    // After all 16 iterations the root sits in the low half of r.
    assign y_vld = vld_q[N-1];
    assign y     = r_q[N-1][15:0];

endmodule

// File: tb/tb_isqrt_pipe.sv
module tb_isqrt_pipe;

    localparam int NDUT = 5;
    localparam int LATS [NDUT] = '{4, 1, 2, 8, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        yv [NDUT];
    logic [15:0] yy [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        isqrt_pipe #(.n_pipe_stages(LATS[g])) u_dut (
            .clk   (clk),
            .rst   (rst),
            .x_vld (x_vld),
            .x     (x),
            .y_vld (yv[g]),
            .y     (yy[g])
        );
    end

    // Reference model: history of offered items (valid + expected root),
    // each DUT shows the item offered LATS[d] edges earlier; y holds the
    // last delivered root and is 0 after reset.
    bit          hv [$];
    logic [15:0] hy [$];
    logic [15:0] last_y [NDUT];
    logic        ev [NDUT];
    logic [15:0] ey [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] isqrt_ref(input logic [31:0] xv);
        longint unsigned lo = 0;
        longint unsigned hi = 65535;
        longint unsigned mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= {32'd0, xv}) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] xv, input logic [15:0] e);
        x_vld = v;
        x     = xv;
        hv.push_back(v);
        hy.push_back(e);
    endtask

    task automatic model_tick();
        int idx;
        for (int d = 0; d < NDUT; d++) begin
            idx = hv.size() - LATS[d];
            if (idx >= 0 && hv[idx]) begin
                ev[d]     = 1'b1;
                ey[d]     = hy[idx];
                last_y[d] = hy[idx];
            end else begin
                ev[d] = 1'b0;
                ey[d] = last_y[d];
            end
        end
    endtask

    task automatic model_reset();
        hv.delete();
        hy.delete();
        for (int d = 0; d < NDUT; d++) last_y[d] = 16'd0;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        x_vld = 1'b0;
        x     = 32'd0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        x_vld = 1'b1;
        x     = 32'd100;
        #2 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== 1'b0 || yy[d] !== 16'd0) begin
                    n_bad++;
                    $display("FAIL reset_hold n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=0 y=0", LATS[d], i, yv[d], yy[d]);
                end
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, $urandom, 16'd0);
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL reset_release n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
        // Fill every pipe with results, then reset between clock edges.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'd100, 16'd10);
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL reset_fill n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
        rst = 1'b0;
        model_reset();
        #2;
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (yv[d] !== 1'b0 || yy[d] !== 16'd0) begin
                n_bad++;
                $display("FAIL reset_async n=%0d: y_vld=%b y=%0d, want y_vld=0 y=0", LATS[d], yv[d], yy[d]);
            end
        end
        x_vld = 1'b1;
        x     = 32'd100;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== 1'b0 || yy[d] !== 16'd0) begin
                    n_bad++;
                    $display("FAIL reset_hold2 n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=0 y=0", LATS[d], i, yv[d], yy[d]);
                end
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, $urandom, 16'd0);
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL reset_spurious n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] sx [7];
        logic [15:0] sy [7];
        sx = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFE_0001, 32'hFFFF_FFFF, 32'hFFFE_0000};
        sy = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd65535, 16'd65535, 16'd65534};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 18; i++) begin
                if (i == 0) drive(1'b1, sx[k], sy[k]);
                else drive(1'b0, $urandom, 16'd0);
                step();
                model_tick();
                for (int d = 0; d < NDUT; d++) begin
                    n_cmp++;
                    if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                        n_bad++;
                        $display("FAIL single x=%0h n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", sx[k], LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bx [8];
        logic [15:0] by [8];
        bx = '{32'd0, 32'd4, 32'd9, 32'd99, 32'd100, 32'd1000000, 32'd2, 32'd3};
        by = '{16'd0, 16'd2, 16'd3, 16'd9, 16'd10, 16'd1000, 16'd1, 16'd1};
        do_reset();
        for (int i = 0; i < 26; i++) begin
            if (i < 8) drive(1'b1, bx[i], by[i]);
            else drive(1'b0, $urandom, 16'd0);
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL back_to_back n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        bit          pv [7];
        logic [31:0] px [7];
        logic [15:0] py [7];
        pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        px = '{32'd49, 32'd0, 32'd0, 32'd50, 32'd48, 32'd0, 32'd225};
        py = '{16'd7, 16'd0, 16'd0, 16'd7, 16'd6, 16'd0, 16'd15};
        do_reset();
        for (int i = 0; i < 25; i++) begin
            if (i < 7) drive(pv[i], pv[i] ? px[i] : $urandom, py[i]);
            else drive(1'b0, $urandom, 16'd0);
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL bubbles n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
    endtask

    task automatic test_squares();
        int unsigned n;
        logic [31:0] sq;
        do_reset();
        for (int i = 0; i < 98; i++) begin
            if (i < 80) begin
                n  = (i < 2) ? 65535 : $urandom_range(65535, 1);
                sq = n * n;
                if (i % 2 == 0) drive(1'b1, sq, n[15:0]);
                else drive(1'b1, sq - 32'd1, n[15:0] - 16'd1);
            end else begin
                drive(1'b0, $urandom, 16'd0);
            end
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL squares n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] mx [3];
        mx = '{32'd49, 32'd64, 32'd100};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mx[i], isqrt_ref(mx[i]));
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL mid_issue n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
        rst   = 1'b0;
        x_vld = 1'b0;
        model_reset();
        #2;
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (yv[d] !== 1'b0 || yy[d] !== 16'd0) begin
                n_bad++;
                $display("FAIL mid_async n=%0d: y_vld=%b y=%0d, want y_vld=0 y=0", LATS[d], yv[d], yy[d]);
            end
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) drive(1'b1, 32'd81, 16'd9);
            else drive(1'b0, $urandom, 16'd0);
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL mid_after n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        bit          v;
        logic [31:0] xv;
        int unsigned n;
        int unsigned mode;
        do_reset();
        for (int i = 0; i < 10018; i++) begin
            if (i < 10000) begin
                v    = ($urandom_range(3) != 0);
                mode = $urandom_range(7);
                case (mode)
                    0:       xv = $urandom_range(1000);
                    1:       xv = 32'hFFFF_FFFF - $urandom_range(200000);
                    2: begin
                        n  = $urandom_range(65535);
                        xv = n * n + $urandom_range(2) - 1;
                    end
                    default: xv = $urandom;
                endcase
                drive(v, xv, isqrt_ref(xv));
            end else begin
                drive(1'b0, $urandom, 16'd0);
            end
            step();
            model_tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (yv[d] !== ev[d] || yy[d] !== ey[d]) begin
                    n_bad++;
                    $display("FAIL sweep n=%0d cyc %0d: y_vld=%b y=%0d, want y_vld=%b y=%0d", LATS[d], i, yv[d], yy[d], ev[d], ey[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) last_y[d] = 16'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bubbles();
        test_squares();
        test_mid_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
